// File: rtl/demux_1_4_buffered.sv
// demux_1_4_buffered: steers one valid/ready input stream to one of four
// output channels. Each channel owns a one-entry registered slot, so a
// stalled consumer only blocks words addressed to its own channel.
module demux_1_4_buffered #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  logic [3:0]       full_s;
  logic [WIDTH-1:0] slot_data_s [4];
  logic             fill_s;

  // The addressed slot can take a word if it is empty or is being drained now.
  // Only sel and y_ready feed this path; d_valid is deliberately left out.
  assign d_ready = !full_s[sel] || y_ready[sel];

  // A word is accepted only when the producer offers it and the slot can take it.
  assign fill_s = d_valid && d_ready;

  for (genvar i = 0; i < 4; i++) begin : g_slot
    slot_state_t      state_r;
    slot_state_t      state_nxt_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic             fill_ch_s;

    // Fill strobe for this channel; sel is only looked at when a word is accepted.
    assign fill_ch_s = fill_s && (sel == 2'(i));

    // Slot next-state: fill wins over drain, so drain plus fill keeps the slot full.
    always_comb begin
      state_nxt_s = state_r;
      data_nxt_s  = data_r;
      case (state_r)
        EMPTY: begin
          if (fill_ch_s) begin
            state_nxt_s = FULL;
            data_nxt_s  = d;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        FULL: begin
          if (fill_ch_s) begin
            state_nxt_s = FULL;
            data_nxt_s  = d;
          end else if (y_ready[i]) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end

    // Slot state and data registers; reset discards any buffered word at once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= EMPTY;
        data_r  <= {WIDTH{1'b0}};
      end else begin
        state_r <= state_nxt_s;
        data_r  <= data_nxt_s;
      end
    end

    assign full_s[i]      = (state_r == FULL);
    assign slot_data_s[i] = data_r;
  end

  // Outputs come straight from the slot registers, never from d.
  assign y_valid = full_s;
  assign y0      = slot_data_s[0];
  assign y1      = slot_data_s[1];
  assign y2      = slot_data_s[2];
  assign y3      = slot_data_s[3];

endmodule
